// File: rtl/neo_lbuf_ctrl.sv
// neo_lbuf_ctrl: double-buffered sprite line-buffer controller and palette-address mixer.
//
// One bank collects sprite pixels for the next line (write bank = ~bsel). The other bank is
// scanned out (display bank = bsel). Each scanned entry is cleared on the next clock.
// After reset, a sweep zeroes both banks before normal operation starts.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   pix_ce              one scanout pixel per pulse (pulses at least one clk apart)
//   line_start          swaps banks, rewinds read pointer, clears wr_ovf
//   wr_load, wr_x       load sprite write pointer
//   wr_flip             0: pointer increments per pixel, 1: decrements
//   wr_valid, wr_color  sprite pixel strobe and colour (0 = transparent)
//   wr_pal              palette of the current sprite strip
//   fix_color, fix_pal  fix-layer pixel (non-zero colour is opaque)
//   blank               forces the video palette address to 0
//   cpu_sel, cpu_addr   CPU override of the palette address bus
//   pa                  palette address (combinational CPU/video mux)
//   wr_ovf              a write fell outside 0..LINE_LEN-1 this line
//   clr_busy            reset clear sweep in progress
module neo_lbuf_ctrl #(
    parameter int unsigned PX_W     = 4,
    parameter int unsigned PAL_W    = 8,
    parameter int unsigned ADDR_W   = 9,
    parameter int unsigned LINE_LEN = 384
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pix_ce,
    input  logic                     line_start,
    input  logic                     wr_load,
    input  logic [ADDR_W-1:0]        wr_x,
    input  logic                     wr_flip,
    input  logic                     wr_valid,
    input  logic [PX_W-1:0]          wr_color,
    input  logic [PAL_W-1:0]         wr_pal,
    input  logic [PX_W-1:0]          fix_color,
    input  logic [3:0]               fix_pal,
    input  logic                     blank,
    input  logic                     cpu_sel,
    input  logic [PAL_W+PX_W-1:0]    cpu_addr,
    output logic [PAL_W+PX_W-1:0]    pa,
    output logic                     wr_ovf,
    output logic                     clr_busy
);
    localparam int unsigned PA_W = PAL_W + PX_W;
    localparam logic [ADDR_W-1:0] LEN_A  = ADDR_W'(LINE_LEN);
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(LINE_LEN - 1);

    typedef enum logic {StInitClr, StRun} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              bsel_q, bsel_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic              wr_ovf_q, wr_ovf_d;
    logic [PA_W-1:0]   rd_data_q, rd_data_d;
    logic [PA_W-1:0]   pa_vid_q, pa_vid_d;
    logic              clr_pend_q, clr_pend_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              clr_bank_q, clr_bank_d;

    logic [PA_W-1:0]   mem [2][LINE_LEN];
    logic              mem_we [2];
    logic [ADDR_W-1:0] mem_wa [2];
    logic [PA_W-1:0]   mem_wd [2];

    logic [ADDR_W-1:0] wr_ptr;
    logic              spr_we;
    logic [PA_W-1:0]   spr_data;
    logic [PA_W-1:0]   rd_word;

    // Only consumed when rptr_q < LINE_LEN.
    assign rd_word = mem[bsel_q][rptr_q];

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        bsel_d     = bsel_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        wr_ovf_d   = wr_ovf_q;
        rd_data_d  = rd_data_q;
        pa_vid_d   = pa_vid_q;
        clr_pend_d = 1'b0;
        clr_addr_d = clr_addr_q;
        clr_bank_d = clr_bank_q;
        // A load applies to a pixel presented in the same cycle.
        wr_ptr     = wr_load ? wr_x : wptr_q;
        spr_we     = 1'b0;
        spr_data   = {wr_pal, wr_color};

        if (line_start) begin
            bsel_d   = ~bsel_q;
            rptr_d   = '0;
            wr_ovf_d = 1'b0;
        end

        unique case (state_q)
            StInitClr: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                rd_data_d = '0;
                pa_vid_d  = '0;
                if (clr_cnt_q == LAST_A) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (wr_load) begin
                    wptr_d = wr_x;
                end
                if (wr_valid) begin
                    wptr_d = wr_flip ? wr_ptr - 1'b1 : wr_ptr + 1'b1;
                    if (wr_ptr >= LEN_A) begin
                        wr_ovf_d = 1'b1;
                    end else if (wr_color != '0) begin
                        spr_we = 1'b1;
                    end
                end
                // line_start beats pix_ce: no read, pa_vid holds.
                if (pix_ce && !line_start) begin
                    if (blank) begin
                        pa_vid_d = '0;
                    end else if (fix_color != '0) begin
                        pa_vid_d = PA_W'({fix_pal, fix_color});
                    end else begin
                        pa_vid_d = rd_data_q;
                    end
                    if (rptr_q < LEN_A) begin
                        rd_data_d  = rd_word;
                        rptr_d     = rptr_q + 1'b1;
                        clr_pend_d = 1'b1;
                        clr_addr_d = rptr_q;
                        clr_bank_d = bsel_q;
                    end else begin
                        rd_data_d = '0;
                    end
                end
            end
            default: state_d = StInitClr;
        endcase
    end

    // Per-bank write-port arbitration. Only the cycle after line_start can see a pending clear
    // and a sprite write on the same bank; the clear wins unless both hit the same address,
    // in which case the newer sprite data is kept.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            mem_we[b] = 1'b0;
            mem_wa[b] = '0;
            mem_wd[b] = '0;
            if (state_q == StInitClr) begin
                mem_we[b] = 1'b1;
                mem_wa[b] = clr_cnt_q;
            end else if (clr_pend_q && (clr_bank_q == 1'(b)) &&
                         !(spr_we && (~bsel_q == 1'(b)) && (wr_ptr == clr_addr_q))) begin
                mem_we[b] = 1'b1;
                mem_wa[b] = clr_addr_q;
            end else if (spr_we && (~bsel_q == 1'(b))) begin
                mem_we[b] = 1'b1;
                mem_wa[b] = wr_ptr;
                mem_wd[b] = spr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < 2; b++) begin
            if (mem_we[b]) begin
                mem[b][mem_wa[b]] <= mem_wd[b];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StInitClr;
            clr_cnt_q  <= '0;
            bsel_q     <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            wr_ovf_q   <= 1'b0;
            rd_data_q  <= '0;
            pa_vid_q   <= '0;
            clr_pend_q <= 1'b0;
            clr_addr_q <= '0;
            clr_bank_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            bsel_q     <= bsel_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            wr_ovf_q   <= wr_ovf_d;
            rd_data_q  <= rd_data_d;
            pa_vid_q   <= pa_vid_d;
            clr_pend_q <= clr_pend_d;
            clr_addr_q <= clr_addr_d;
            clr_bank_q <= clr_bank_d;
        end
    end

    assign pa       = cpu_sel ? cpu_addr : pa_vid_q;
    assign wr_ovf   = wr_ovf_q;
    assign clr_busy = (state_q == StInitClr);

endmodule

// File: tb/tb_neo_lbuf_ctrl.sv
// Directed testbench for neo_lbuf_ctrl with default parameters.
module tb_neo_lbuf_ctrl;
    localparam int PX_W     = 4;
    localparam int PAL_W    = 8;
    localparam int ADDR_W   = 9;
    localparam int LINE_LEN = 384;
    localparam int PA_W     = PAL_W + PX_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              pix_ce, line_start, wr_load, wr_flip, wr_valid, blank, cpu_sel;
    logic [ADDR_W-1:0] wr_x;
    logic [PX_W-1:0]   wr_color, fix_color;
    logic [PAL_W-1:0]  wr_pal;
    logic [3:0]        fix_pal;
    logic [PA_W-1:0]   cpu_addr;
    logic [PA_W-1:0]   pa;
    logic              wr_ovf, clr_busy;

    int total = 0;
    int bad   = 0;
    logic [PA_W-1:0] sbuf [0:399];

    always #5 clk = ~clk;

    neo_lbuf_ctrl #(
        .PX_W(PX_W), .PAL_W(PAL_W), .ADDR_W(ADDR_W), .LINE_LEN(LINE_LEN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .line_start(line_start),
        .wr_load(wr_load), .wr_x(wr_x), .wr_flip(wr_flip), .wr_valid(wr_valid),
        .wr_color(wr_color), .wr_pal(wr_pal), .fix_color(fix_color), .fix_pal(fix_pal),
        .blank(blank), .cpu_sel(cpu_sel), .cpu_addr(cpu_addr), .pa(pa),
        .wr_ovf(wr_ovf), .clr_busy(clr_busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [ADDR_W-1:0] x, input logic f, input logic [PAL_W-1:0] p);
        wr_load = 1'b1; wr_x = x; wr_flip = f; wr_pal = p;
        tick();
        wr_load = 1'b0;
    endtask

    task automatic put(input logic [PX_W-1:0] c);
        wr_valid = 1'b1; wr_color = c;
        tick();
        wr_valid = 1'b0; wr_color = '0;
    endtask

    task automatic new_line;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
    endtask

    // Pulse k (1-based) captures pa into sbuf[k]; it carries pixel k-2.
    task automatic scan(input int n);
        for (int k = 1; k <= n; k++) begin
            pix_ce = 1'b1;
            tick();
            sbuf[k] = pa;
            pix_ce = 1'b0;
            tick();
        end
    endtask

    task automatic sweep_len(output int cnt);
        cnt = 0;
        while (clr_busy && cnt < 2000) begin
            tick();
            cnt++;
        end
    endtask

    task automatic test_reset;
        int cnt;
        rst_n = 1'b0;
        repeat (3) tick();
        total++;
        if (clr_busy !== 1'b1 || pa !== '0 || wr_ovf !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got busy=%b pa=%h ovf=%b want busy=1 pa=000 ovf=0",
                     clr_busy, pa, wr_ovf);
        end
        cpu_sel = 1'b1; cpu_addr = 12'hABC;
        #1;
        total++;
        if (pa !== 12'hABC) begin
            bad++;
            $display("FAIL reset_cpu_pa: got %h want abc", pa);
        end
        cpu_sel = 1'b0; cpu_addr = '0;
        rst_n = 1'b1;
        sweep_len(cnt);
        total++;
        if (cnt !== LINE_LEN) begin
            bad++;
            $display("FAIL sweep_len: got %0d want %0d", cnt, LINE_LEN);
        end
    endtask

    task automatic test_sweep;
        int cnt;
        int nz;
        // Fill both banks with 0xAB.
        load(0, 1'b0, 8'h0A);
        for (int i = 0; i < LINE_LEN; i++) put(4'hB);
        new_line();
        load(0, 1'b0, 8'h0A);
        for (int i = 0; i < LINE_LEN; i++) put(4'hB);
        rst_n = 1'b0;
        #1;
        total++;
        if (clr_busy !== 1'b1) begin
            bad++;
            $display("FAIL async_reset_busy: got %b want 1", clr_busy);
        end
        tick();
        rst_n = 1'b1;
        sweep_len(cnt);
        total++;
        if (cnt !== LINE_LEN) begin
            bad++;
            $display("FAIL resweep_len: got %0d want %0d", cnt, LINE_LEN);
        end
        for (int bank = 0; bank < 2; bank++) begin
            new_line();
            scan(LINE_LEN + 2);
            nz = 0;
            for (int k = 1; k <= LINE_LEN + 2; k++) if (sbuf[k] !== '0) nz++;
            total++;
            if (nz != 0) begin
                bad++;
                $display("FAIL sweep_scan%0d: got %0d nonzero pixels want 0", bank, nz);
            end
        end
    endtask

    task automatic test_write_scan;
        int p;
        logic [PA_W-1:0] exp;
        load(10, 1'b0, 8'h12);
        for (int c = 1; c <= 4; c++) put(4'(c));
        new_line();
        scan(16);
        for (int k = 1; k <= 16; k++) begin
            p = k - 2;
            exp = (p >= 10 && p <= 13) ? 12'(32'h120 + p - 9) : '0;
            total++;
            if (sbuf[k] !== exp) begin
                bad++;
                $display("FAIL write_scan_px%0d: got %h want %h", p, sbuf[k], exp);
            end
        end
        new_line();
        new_line();
        scan(16);
        for (int k = 1; k <= 16; k++) begin
            total++;
            if (sbuf[k] !== '0) begin
                bad++;
                $display("FAIL rescan_cleared_px%0d: got %h want 000", k - 2, sbuf[k]);
            end
        end
    endtask

    task automatic test_flip;
        logic [PA_W-1:0] exp;
        load(19, 1'b0, 8'h55);
        put(4'h9);
        load(20, 1'b1, 8'h3C);
        put(4'h5);
        put(4'h0);
        put(4'h7);
        new_line();
        scan(22);
        for (int k = 1; k <= 22; k++) begin
            exp = (k == 20) ? 12'h3C7 : (k == 21) ? 12'h559 : (k == 22) ? 12'h3C5 : '0;
            total++;
            if (sbuf[k] !== exp) begin
                bad++;
                $display("FAIL flip_px%0d: got %h want %h", k - 2, sbuf[k], exp);
            end
        end
    endtask

    task automatic test_overflow;
        int nz;
        load(383, 1'b0, 8'h21);
        put(4'h6);
        total++;
        if (wr_ovf !== 1'b0) begin
            bad++;
            $display("FAIL ovf_hi_first: got %b want 0", wr_ovf);
        end
        put(4'h6);
        repeat (2) tick();
        total++;
        if (wr_ovf !== 1'b1) begin
            bad++;
            $display("FAIL ovf_hi_set: got %b want 1", wr_ovf);
        end
        new_line();
        total++;
        if (wr_ovf !== 1'b0) begin
            bad++;
            $display("FAIL ovf_hi_clear: got %b want 0", wr_ovf);
        end
        scan(LINE_LEN + 2);
        nz = 0;
        for (int k = 1; k <= LINE_LEN; k++) if (sbuf[k] !== '0) nz++;
        total++;
        if (nz != 0) begin
            bad++;
            $display("FAIL ovf_hi_others: got %0d nonzero want 0", nz);
        end
        total++;
        if (sbuf[LINE_LEN + 1] !== 12'h216) begin
            bad++;
            $display("FAIL ovf_hi_px383: got %h want 216", sbuf[LINE_LEN + 1]);
        end
        total++;
        if (sbuf[LINE_LEN + 2] !== '0) begin
            bad++;
            $display("FAIL ovf_hi_px384: got %h want 000", sbuf[LINE_LEN + 2]);
        end
        load(0, 1'b1, 8'h22);
        put(4'h8);
        total++;
        if (wr_ovf !== 1'b0) begin
            bad++;
            $display("FAIL ovf_lo_first: got %b want 0", wr_ovf);
        end
        put(4'h8);
        total++;
        if (wr_ovf !== 1'b1) begin
            bad++;
            $display("FAIL ovf_lo_set: got %b want 1", wr_ovf);
        end
        new_line();
        total++;
        if (wr_ovf !== 1'b0) begin
            bad++;
            $display("FAIL ovf_lo_clear: got %b want 0", wr_ovf);
        end
        scan(3);
        total++;
        if (sbuf[1] !== '0 || sbuf[2] !== 12'h228 || sbuf[3] !== '0) begin
            bad++;
            $display("FAIL ovf_lo_scan: got %h %h %h want 000 228 000", sbuf[1], sbuf[2], sbuf[3]);
        end
    endtask

    task automatic test_priority;
        load(0, 1'b0, 8'h34);
        for (int i = 0; i < 5; i++) put(4'h5);
        new_line();
        scan(1);
        fix_color = 4'h2; fix_pal = 4'h9;
        pix_ce = 1'b1; tick(); pix_ce = 1'b0;
        total++;
        if (pa !== 12'h092) begin
            bad++;
            $display("FAIL prio_fix: got %h want 092", pa);
        end
        tick();
        blank = 1'b1;
        pix_ce = 1'b1; tick(); pix_ce = 1'b0;
        total++;
        if (pa !== 12'h000) begin
            bad++;
            $display("FAIL prio_blank: got %h want 000", pa);
        end
        tick();
        blank = 1'b0; fix_color = 4'h0;
        pix_ce = 1'b1; tick(); pix_ce = 1'b0;
        total++;
        if (pa !== 12'h345) begin
            bad++;
            $display("FAIL prio_sprite: got %h want 345", pa);
        end
        fix_pal = 4'h0;
        cpu_sel = 1'b1; cpu_addr = 12'hFED;
        #1;
        total++;
        if (pa !== 12'hFED) begin
            bad++;
            $display("FAIL prio_cpu: got %h want fed", pa);
        end
        cpu_sel = 1'b0;
        #1;
        total++;
        if (pa !== 12'h345) begin
            bad++;
            $display("FAIL prio_cpu_release: got %h want 345", pa);
        end
        cpu_addr = '0;
        tick();
    endtask

    task automatic test_back_to_back;
        logic [PA_W-1:0] exp;
        load(7, 1'b0, 8'h4E);
        line_start = 1'b1; wr_valid = 1'b1; wr_color = 4'hA; pix_ce = 1'b1;
        tick();
        line_start = 1'b0; wr_valid = 1'b0; wr_color = '0; pix_ce = 1'b0;
        total++;
        if (pa !== 12'h345) begin
            bad++;
            $display("FAIL collide_hold: got %h want 345", pa);
        end
        tick();
        scan(9);
        for (int k = 2; k <= 9; k++) begin
            exp = (k == 9) ? 12'h4EA : '0;
            total++;
            if (sbuf[k] !== exp) begin
                bad++;
                $display("FAIL collide_px%0d: got %h want %h", k - 2, sbuf[k], exp);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; pix_ce = 1'b0; line_start = 1'b0; wr_load = 1'b0; wr_x = '0;
        wr_flip = 1'b0; wr_valid = 1'b0; wr_color = '0; wr_pal = '0; fix_color = '0;
        fix_pal = '0; blank = 1'b0; cpu_sel = 1'b0; cpu_addr = '0;
        test_reset();
        test_sweep();
        test_write_scan();
        test_flip();
        test_overflow();
        test_priority();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/neo_lbuf_ctrl.md
# neo_lbuf_ctrl

Parametrised double-buffered sprite line-buffer controller and palette-address mixer for the NEO video path. One bank collects the sprite pixels for the next line while the other bank is scanned out and cleared behind the read pointer. The scanned sprite pixel is merged with the fix layer, blanking and the CPU palette override to drive the palette address bus. Compared with the fixed four-RAM pixel-pair arrangement, it adds configurable widths and line length, transparency-skipping writes with flip, overflow detection, and a self-clearing reset sweep.

## Interface
- PX_W, 4, colour index bits per pixel
- PAL_W, 8, palette number bits; PA width is PAL_W+PX_W
- ADDR_W, 9, line-buffer address bits; 2^ADDR_W must exceed LINE_LEN
- LINE_LEN, 384, pixels per line (valid addresses 0..LINE_LEN-1)

Ports:
- CLK  in  1  system clock; the only clock
- nRST  in  1  reset, asynchronous, active-low
- PIX_CE  in  1  pixel clock enable (one scanout pixel per pulse)
- LINE_START  in  1  one-cycle pulse at line start; swaps banks
- WR_LOAD  in  1  load write pointer from WR_X
- WR_X  in  ADDR_W  sprite strip start X
- WR_FLIP  in  1  0: pointer increments per pixel, 1: decrements
- WR_VALID  in  1  one sprite pixel presented this cycle
- WR_COLOR  in  PX_W  sprite pixel colour; 0 is transparent
- WR_PAL  in  PAL_W  palette of the current strip
- FIX_COLOR  in  PX_W  fix pixel; non-zero is opaque
- FIX_PAL  in  4  fix palette
- BLANK  in  1  force sprite/fix output to 0
- CPU_SEL  in  1  CPU owns palette bus
- CPU_ADDR  in  PAL_W+PX_W  CPU palette address
- PA  out  PAL_W+PX_W  palette address
- WR_OVF  out  1  a write was attempted outside 0..LINE_LEN-1 this line
- CLR_BUSY  out  1  reset clear sweep in progress

## Operation
- Storage: two banks of LINE_LEN entries of PAL_W+PX_W bits. BSEL selects the display bank; the write bank is ~BSEL. Each bank has one write port and one synchronous read port.
- FSM with two states: INIT_CLR and RUN.
  - Reset enters INIT_CLR. A sweep counter runs 0..LINE_LEN-1 and writes 0 to both banks, one address per CLK.
  - After address LINE_LEN-1 the FSM moves to RUN.
  - In INIT_CLR, WR_VALID is ignored and the PA video register holds 0.
- Sprite write (RUN only):
  - WR_LOAD sets WPTR=WR_X. WR_LOAD has priority over WR_VALID in the same cycle; that pixel is written at WR_X.
  - Each WR_VALID writes {WR_PAL, WR_COLOR} to the write bank at WPTR, then WPTR moves ±1 according to WR_FLIP, modulo 2^ADDR_W.
  - WR_COLOR==0 writes nothing, but WPTR still advances.
  - If WPTR≥LINE_LEN, the write is dropped and WR_OVF is set. WR_OVF is cleared on LINE_START.
- Scanout (RUN only):
  - On LINE_START, RPTR=0.
  - On each PIX_CE, the display bank is read at RPTR. The same entry is written to 0 on the next CLK (clear-after-read), and RPTR increments, saturating at LINE_LEN.
  - Reads at RPTR≥LINE_LEN return 0 and perform no clear.
- Mix, evaluated at the PIX_CE that registers the pixel:
  - BLANK gives 0.
  - Otherwise, FIX_COLOR≠0 gives {0…, FIX_PAL, FIX_COLOR}.
  - Otherwise, the sprite entry read on the previous PIX_CE is used.
  - The result is stored in the PA_VID register.
- PA = CPU_SEL ? CPU_ADDR : PA_VID. This path is combinational, with no register.

## Timing
- Reset values: PA_VID=0, PA=CPU_SEL?CPU_ADDR:0, BSEL=0, WPTR=0, RPTR=0, WR_OVF=0, CLR_BUSY=1.
- CLR_BUSY is high for exactly LINE_LEN CLK cycles after nRST deasserts, then falls.
- Scanout latency: pixel at address n reaches PA_VID on the (n+2)th PIX_CE after LINE_START, which is 2 PIX_CE of latency.
- Write latency: an entry written at cycle t is readable from cycle t+1, once that bank becomes the display bank.
- LINE_START with WR_VALID in the same cycle: the pixel is written to the pre-swap write bank. BSEL toggles at the end of that cycle.
- LINE_START with PIX_CE in the same cycle: LINE_START wins. RPTR=0, no read occurs, PA_VID holds.
- A pending clear of the last read address still completes in the cycle after LINE_START, on the old display bank.
- LINE_START during INIT_CLR toggles BSEL; the sweep is unaffected.
- nRST asserted mid-line aborts everything immediately. The sweep restarts on release.
- PIX_CE must be deasserted for at least one CLK between pulses. This leaves a free cycle for the clear write.

## Test plan
- Reset sweep: fill both banks with 0xAB, pulse nRST, wait LINE_LEN+2 cycles → CLR_BUSY fell after exactly 384 cycles; a full scanout of both banks gives PA=0 everywhere.
- Write and scan: load X=10 with flip=0, pal=0x12, write colours 1..4, then LINE_START and 16 PIX_CE → PA_VID sequence at pixels 10..13 is 0x121, 0x122, 0x123, 0x124; all others 0; rescanning the same bank gives all 0 (cleared).
- Transparency and flip: X=20, flip=1, colours 5,0,7 → address 20=0x..5, 19 unchanged, 18=0x..7.
- Overflow: X=383, flip=0, two pixels → 383 written, second dropped, WR_OVF=1 until next LINE_START; X=0, flip=1, two pixels → address 0 written, WR_OVF=1.
- Priority: sprite 0x345 under FIX_COLOR=2, FIX_PAL=9 → PA=0x092; BLANK=1 → 0x000; CPU_SEL=1, CPU_ADDR=0xFED → PA=0xFED the same cycle.
- Collisions: LINE_START together with WR_VALID and PIX_CE → pixel lands in the old write bank and is visible on the following line; RPTR=0; PA_VID unchanged.
